// File: rtl/sisc_rf_pkg.sv
// Shared defaults, the R0 address and a flattened-port field extractor for the SISC register file.
package sisc_rf_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 4;
    localparam int R0_ADDR     = 0;
    localparam int FIELD_MAX_W = 64;
    localparam int VEC_MAX_W   = 256;

    // Returns field p of width w from a vector of equal-width fields packed LSB-first.
    function automatic logic [FIELD_MAX_W-1:0] port_field(
        input logic [VEC_MAX_W-1:0] vec,
        input int unsigned          w,
        input int unsigned          p
    );
        logic [VEC_MAX_W-1:0]   shifted;
        logic [FIELD_MAX_W-1:0] f;
        shifted = vec >> (p * w);
        f = '0;
        for (int i = 0; i < FIELD_MAX_W; i++) begin
            if (i < int'(w)) f[i] = shifted[i];
        end
        return f;
    endfunction

endpackage

// File: rtl/rf_sb_rdport.sv
// One registered read port: address mux, R0 handling, optional same-edge write bypass (RF_BYPASS_EN).
module rf_sb_rdport
    import sisc_rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    mem [2**ADDR_W],
    input  logic [2**ADDR_W-1:0] busy,
`ifdef RF_BYPASS_EN
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 rsv_en,
    input  logic [ADDR_W-1:0]    rsv_addr,
`endif
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rd_valid,
    output logic                 rd_ready
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(R0_ADDR);

    logic [DATA_W-1:0] next_data;
    logic              next_ready;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_data  = mem[addr];
        next_ready = !busy[addr];
`ifdef RF_BYPASS_EN
        if (wr_en && (wr_addr == addr)) begin
            next_data  = wr_data;
            next_ready = !(rsv_en && (rsv_addr == addr));
        end
`endif
        // R0 overrides the bypass as well: its writes are dropped anyway.
        if ((ZERO_REG != 0) && (addr == ZERO_ADDR)) begin
            next_data  = '0;
            next_ready = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_ready <= 1'b0;
        end else if (en) begin
            rd_data  <= next_data;
            rd_valid <= 1'b1;
            rd_ready <= next_ready;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_sb.sv
// Parametrised register file with pending-write scoreboard and NUM_RD registered read ports.
// Optional same-edge write-to-read bypass is enabled by defining RF_BYPASS_EN.
module rf_sb
    import sisc_rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [NUM_RD-1:0]        rd_ready,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [2**ADDR_W-1:0]     busy
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam bit                HAS_ZERO  = (ZERO_REG != 0);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(R0_ADDR);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;

    assign wr_ok = wr_en && !(HAS_ZERO && (wr_addr == ZERO_ADDR));

    // NOTE: the storage array is reset because every word must read as zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_ok) mem[wr_addr] <= wr_data;
            // A same-edge reserve wins over a write: it belongs to a newer producer.
            for (int r = 0; r < DEPTH; r++) begin
                if (HAS_ZERO && (r == R0_ADDR))
                    busy[r] <= 1'b0;
                else if (rsv_en && (rsv_addr == ADDR_W'(r)))
                    busy[r] <= 1'b1;
                else if (wr_en && (wr_addr == ADDR_W'(r)))
                    busy[r] <= 1'b0;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] port_addr;
        assign port_addr = ADDR_W'(port_field(VEC_MAX_W'(rd_addr), ADDR_W, p));

        rf_sb_rdport #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) u_rdport (
            .clk     (clk),
            .rst     (rst),
            .en      (rd_en[p]),
            .addr    (port_addr),
            .mem     (mem),
            .busy    (busy),
`ifdef RF_BYPASS_EN
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rsv_en  (rsv_en),
            .rsv_addr(rsv_addr),
`endif
            .rd_data (rd_data[p*DATA_W +: DATA_W]),
            .rd_valid(rd_valid[p]),
            .rd_ready(rd_ready[p])
        );
    end

endmodule
